coeff_loader: RTL

COEFF_LOADER -- requirements
Module: coeff_loader

---
 rtl/coeff_loader.sv | 98 +++++++++
 1 files changed

// File: rtl/coeff_loader.sv
// Serial coefficient loader: fills a shadow bank one word per handshake, then commits it whole to the active bank.
// Latency: the active bank updates on the first COMMIT edge with sample_valid=0; load_done is high the cycle after.
// Backpressure: coeff_ready is high only in LOAD; commit waits while sample_valid=1 so taps never split across a sample.
module coeff_loader #(
  parameter int WORD_LENGTH  = 16,
  parameter int FILTER_ORDER = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                load_start,
  input  logic                                coeff_valid,
  input  logic [WORD_LENGTH-1:0]              coeff_in,
  output logic                                coeff_ready,
  input  logic                                sample_valid,
  output logic [FILTER_ORDER*WORD_LENGTH-1:0] Coefficient,
  output logic [$clog2(FILTER_ORDER)-1:0]     coeff_index,
  output logic                                load_done
);

  localparam int IDX_W = $clog2(FILTER_ORDER);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FILTER_ORDER - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state;

  // Shadow bank collects the incoming tap set before it becomes visible.
  logic [WORD_LENGTH-1:0] shadow [FILTER_ORDER];

  // Handshake is registered from state only; a restart wins over a word arriving in the same cycle.
  wire accept = coeff_valid && coeff_ready && !load_start && (state == LOAD);

  // Control FSM with registered outputs: sequences load, waits for a sample gap, then copies the bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      coeff_index <= '0;
      coeff_ready <= 1'b0;
      load_done   <= 1'b0;
      Coefficient <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state       <= LOAD;
            coeff_index <= '0;
            coeff_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            coeff_index <= '0;
          end else if (accept) begin
            if (coeff_index == LAST_IDX) begin
              state       <= COMMIT;
              coeff_index <= '0;
              coeff_ready <= 1'b0;
            end else begin
              coeff_index <= coeff_index + IDX_W'(1);
            end
          end
        end
        COMMIT: begin
          // load_start is deliberately not looked at here; a new load needs a fresh request from IDLE.
          if (!sample_valid) begin
            for (int i = 0; i < FILTER_ORDER; i++) begin
              Coefficient[i*WORD_LENGTH +: WORD_LENGTH] <= shadow[i];
            end
            load_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          coeff_index <= '0;
          coeff_ready <= 1'b0;
        end
      endcase
    end
  end

  // Shadow write port: accepted words land unmodified at the current slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FILTER_ORDER; i++) begin
        shadow[i] <= '0;
      end
    end else if (accept) begin
      shadow[coeff_index] <= coeff_in;
    end
  end

endmodule
